// File: rtl/ifetch.sv
// Instruction fetch stage: PC, one-deep request pipeline to a fixed-latency memory,
// and a 2-entry {inst, addr} queue toward decode with EX-driven redirect.
module ifetch #(
    parameter int                WORD       = 32,
    parameter int                ADDR       = 32,
    parameter logic [ADDR-1:0]   RESET_ADDR = {ADDR{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [ADDR-1:0]   imem_addr_o,
    input  logic [WORD-1:0]   imem_data_i,
    input  logic              br_i,
    input  logic [ADDR-1:0]   br_addr_i,
    output logic              v_o,
    output logic [WORD-1:0]   inst_o,
    output logic [ADDR-1:0]   origaddr_o,
    input  logic              stall_i
);

    localparam logic [ADDR-1:0] STEP = {{(ADDR-3){1'b0}}, 3'b100};

    logic [ADDR-1:0] pc_r;
    logic [ADDR-1:0] req_addr_r;
    logic            inflight_r;
    logic [WORD-1:0] inst_q_r [2];
    logic [ADDR-1:0] addr_q_r [2];
    logic            head_r;
    logic [1:0]      count_r;

    logic            br_s;
    logic [ADDR-1:0] target_s;
    logic            v_s;
    logic            pop_s;
    logic            push_s;
    logic            req_s;
    logic            tail_s;
    logic [2:0]      occ_s;
    logic [ADDR-1:0] addr_s;
    logic            unused_s;

    // Redirect target bits [1:0] are forced to zero, so they are deliberately left unread.
    assign unused_s = ^br_addr_i[1:0];
    assign target_s = {br_addr_i[ADDR-1:2], 2'b00};

    // Queue control and memory request decision; reset gates every request path.
    always_comb begin
        br_s   = rst & br_i;
        v_s    = (count_r != 2'd0) & ~br_s;
        pop_s  = v_s & ~stall_i;
        push_s = inflight_r & ~br_s;
        occ_s  = {1'b0, count_r} + {2'b00, inflight_r};
        tail_s = head_r ^ count_r[0];
        if (!rst) begin
            req_s = 1'b0;
        end else if (br_s) begin
            req_s = 1'b1;
        end else begin
            req_s = ((occ_s - {2'b00, pop_s}) < 3'd2);
        end
        if (br_s) begin
            addr_s = target_s;
        end else begin
            addr_s = pc_r;
        end
    end

    assign imem_req_o  = req_s;
    assign imem_addr_o = addr_s;
    assign v_o         = v_s;
    assign inst_o      = inst_q_r[head_r];
    assign origaddr_o  = addr_q_r[head_r];

    // PC, inflight tracking and queue storage; a redirect overrides push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r        <= RESET_ADDR;
            req_addr_r  <= RESET_ADDR;
            inflight_r  <= 1'b0;
            head_r      <= 1'b0;
            count_r     <= 2'd0;
            inst_q_r[0] <= {WORD{1'b0}};
            inst_q_r[1] <= {WORD{1'b0}};
            addr_q_r[0] <= {ADDR{1'b0}};
            addr_q_r[1] <= {ADDR{1'b0}};
        end else if (br_s) begin
            pc_r       <= target_s + STEP;
            req_addr_r <= target_s;
            inflight_r <= 1'b1;
            head_r     <= 1'b0;
            count_r    <= 2'd0;
        end else begin
            inflight_r <= req_s;
            if (req_s) begin
                pc_r       <= pc_r + STEP;
                req_addr_r <= pc_r;
            end else begin
                pc_r       <= pc_r;
                req_addr_r <= req_addr_r;
            end
            if (push_s) begin
                inst_q_r[tail_s] <= imem_data_i;
                addr_q_r[tail_s] <= req_addr_r;
            end else begin
                inst_q_r[tail_s] <= inst_q_r[tail_s];
                addr_q_r[tail_s] <= addr_q_r[tail_s];
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end else begin
                head_r <= head_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL have parameter WORD, default 32, meaning the instruction width in bits.
REQ-002 The block SHALL have parameter ADDR, default 32, meaning the byte-address width in bits.
REQ-003 The block SHALL have parameter RESET_ADDR, default 0, meaning the first fetch address after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port imem_req_o, output, 1 bit: instruction memory read request this cycle.
REQ-007 The block SHALL have port imem_addr_o, output, ADDR bits: read address, word-aligned.
REQ-008 The block SHALL have port imem_data_i, input, WORD bits: read data, valid exactly 1 cycle after its request; the memory never stalls.
REQ-009 The block SHALL have port br_i, input, 1 bit: redirect request from EX (taken branch or jump).
REQ-010 The block SHALL have port br_addr_i, input, ADDR bits: redirect target; bits [1:0] are ignored and treated as 0.
REQ-011 The block SHALL have port v_o, output, 1 bit: inst_o and origaddr_o are valid.
REQ-012 The block SHALL have port inst_o, output, WORD bits: fetched instruction, to the decode stage.
REQ-013 The block SHALL have port origaddr_o, output, ADDR bits: byte address of inst_o.
REQ-014 The block SHALL have port stall_i, input, 1 bit: decode cannot accept this cycle; the head entry is held.

Function
REQ-015 The block SHALL keep a PC register, a 2-entry FIFO of {inst, addr} pairs, and an inflight flag marking a request issued in the previous cycle.
REQ-016 The block SHALL compute pop = v_o & ~stall_i; a popped entry leaves the FIFO at the clock edge.
REQ-017 The block SHALL compute occ = FIFO count + inflight.
- Without a redirect, imem_req_o SHALL be asserted iff (occ - pop) < 2.
- This sustains 1 instruction per cycle when stall_i stays low.
REQ-018 On a request without a redirect, the block SHALL drive imem_addr_o = PC and update PC <= PC + 4.
REQ-019 When inflight is set, the block SHALL push {imem_data_i, address of that request} into the FIFO, unless REQ-022 discards it.
- A push and a pop in the same cycle SHALL both take effect.
REQ-020 The block SHALL drive v_o = (FIFO count != 0) & ~br_i.
- inst_o and origaddr_o SHALL show the FIFO head.
- While stall_i is high, inst_o and origaddr_o SHALL hold stable.
REQ-021 The block SHALL never push into a full FIFO; REQ-017 guarantees this, and the bench SHALL check it by assertion.
REQ-022 When br_i is high (the redirect cycle):
- FIFO SHALL be cleared;
- the response arriving in that cycle SHALL be discarded;
- imem_req_o SHALL be 1 with imem_addr_o = br_addr_i;
- PC SHALL become br_addr_i + 4;
- inflight SHALL become 1.
REQ-023 br_i SHALL take priority over stall_i and over any push or pop in the same cycle.
REQ-024 Redirect latency: with br_i high in cycle N and stall_i low, v_o SHALL rise in cycle N+2 with origaddr_o = br_addr_i.
REQ-025 PC arithmetic SHALL wrap modulo 2^ADDR; after fetching 2^ADDR - 4 the next fetch address is 0.
REQ-026 Back-to-back redirects SHALL each take effect; only the target of the last redirect is delivered.

Reset
REQ-027 While rst is low, the block SHALL hold:
- v_o = 0, inst_o = 0, origaddr_o = 0;
- imem_req_o = 0, imem_addr_o = RESET_ADDR;
- PC = RESET_ADDR, FIFO empty, inflight = 0.
REQ-028 In the first cycle after rst deasserts, the block SHALL request RESET_ADDR; v_o SHALL rise 2 cycles later with origaddr_o = RESET_ADDR.
REQ-029 A reset asserted mid-operation SHALL discard FIFO contents and the inflight response immediately; no stale instruction SHALL appear after release.

Verification
REQ-030 Reset release, stall_i = 0, memory returns addr-tagged data -> v_o from cycle 2; origaddr_o = 0, 4, 8, ... one per cycle; no gaps.
REQ-031 stall_i held high for 5 cycles from steady state -> FIFO fills to 2; imem_req_o = 0 while full; inst_o stable; after release, addresses continue in order with none lost or duplicated.
REQ-032 br_i = 1 with br_addr_i = 0x103 while the FIFO holds 2 entries -> v_o = 0 that cycle; imem_addr_o = 0x100; at N+2, origaddr_o = 0x100; then 0x104.
REQ-033 br_i and stall_i both high in the same cycle -> redirect wins; FIFO cleared; the wrong-path instruction is never presented with v_o = 1.
REQ-034 RESET_ADDR = 0xFFFFFFF8 -> fetch sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-035 rst pulsed low mid-stream with the FIFO full -> outputs go to their reset values asynchronously; after release, fetch restarts at RESET_ADDR.
